// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types and constants for the byte-serialising memory
//                controller: FSM state encoding, mem_len_i codes, IO region
//                tag and a helper that turns a length code into a byte count.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } mem_state_e;

    localparam logic [1:0] c_LEN_BYTE = 2'b00;
    localparam logic [1:0] c_LEN_HALF = 2'b01;
    localparam logic [1:0] c_LEN_WORD = 2'b11;

    // Address bits [17:16] equal to this tag select the UART/IO region.
    localparam logic [1:0] c_IO_TAG   = 2'b11;

    // Number of bytes moved for a length code; the unused code 2'b10 is
    // treated as a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            c_LEN_BYTE: len_bytes = 3'd1;
            c_LEN_HALF: len_bytes = 3'd2;
            c_LEN_WORD: len_bytes = 3'd4;
            default:    len_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_if
//  Description : Bundle of the pipeline request/response signals and the
//                8-bit RAM/IO port around mem_ctrl.
//                slave  : the controller side (mem_ctrl)
//                master : the environment side (IF/MEM stages and RAM)
//  Ports       : if_req_i/if_addr_i/if_flush_i      fetch request
//                mem_req_i/mem_we_i/mem_len_i/
//                mem_addr_i/mem_wdata_i              load/store request
//                io_buffer_full_i                    UART back-pressure
//                mem_din_i                           RAM read byte
//                mem_a_o/mem_dout_o/mem_wr_o         RAM port
//                if_done_o/if_data_o                 fetch response
//                mem_done_o/mem_data_o               load/store response
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_ctrl_if;

    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        io_buffer_full_i;
    logic [7:0]  mem_din_i;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        mem_done_o;
    logic [31:0] mem_data_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        input  io_buffer_full_i, mem_din_i,
        output mem_a_o, mem_dout_o, mem_wr_o,
        output if_done_o, if_data_o, mem_done_o, mem_data_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        output io_buffer_full_i, mem_din_i,
        input  mem_a_o, mem_dout_o, mem_wr_o,
        input  if_done_o, if_data_o, mem_done_o, mem_data_o
    );

endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Serialises fetch word reads and MEM-stage loads/stores into
//                byte accesses on a single 8-bit RAM/IO port (1-cycle read
//                latency) and returns little-endian words with a one-cycle
//                done pulse. MEM requests win over fetches.
//  Ports       : clk  system clock
//                rst  synchronous active-high reset
//                bus  mem_ctrl_if.slave (pipeline requests + RAM port)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    mem_state_e  r_state;
    logic [2:0]  r_cnt;      // index of the address currently on the port
    logic [2:0]  r_n;        // bytes in the current transaction
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;

    logic [2:0]  w_len_n;
    logic        w_io_block;
    logic        w_done_busy;
    logic        w_mem_go;
    logic        w_if_go;
    logic [1:0]  w_cap_idx;
    logic [1:0]  w_wr_idx;
    logic [31:0] w_next_addr;
    logic [31:0] w_buf_next;
    logic [7:0]  w_next_wbyte;
    logic        w_more;

    always_comb begin
        w_len_n     = len_bytes(bus.mem_len_i);
        w_io_block  = bus.mem_we_i && bus.io_buffer_full_i &&
                      (bus.mem_addr_i[17:16] == c_IO_TAG);
        // No new acceptance while a done pulse is still on the outputs, so
        // the requester has a cycle to drop its request.
        w_done_busy = bus.if_done_o || bus.mem_done_o;
        w_mem_go    = bus.mem_req_i && !w_io_block && !w_done_busy;
        // A pending (even blocked) MEM request keeps the fetch waiting.
        w_if_go     = bus.if_req_i && !bus.if_flush_i && !w_done_busy &&
                      !bus.mem_req_i;

        // The byte arriving now belongs to the address issued one cycle ago.
        w_cap_idx   = r_cnt[1:0] - 2'd1;
        w_buf_next  = r_buf;
        w_buf_next[{w_cap_idx, 3'b000} +: 8] = bus.mem_din_i;

        w_next_addr = r_addr + {29'd0, r_cnt} + 32'd1;
        w_wr_idx    = r_cnt[1:0] + 2'd1;
        w_next_wbyte = r_wdata[{w_wr_idx, 3'b000} +: 8];
        w_more      = (r_cnt + 3'd1) < r_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 3'd0;
            r_n            <= 3'd0;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            r_buf          <= 32'd0;
            bus.mem_a_o    <= 32'd0;
            bus.mem_dout_o <= 8'd0;
            bus.mem_wr_o   <= 1'b0;
            bus.if_done_o  <= 1'b0;
            bus.if_data_o  <= 32'd0;
            bus.mem_done_o <= 1'b0;
            bus.mem_data_o <= 32'd0;
        end else begin
            bus.if_done_o  <= 1'b0;
            bus.mem_done_o <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_mem_go) begin
                        r_addr      <= bus.mem_addr_i;
                        r_wdata     <= bus.mem_wdata_i;
                        r_n         <= w_len_n;
                        r_buf       <= 32'd0;
                        bus.mem_a_o <= bus.mem_addr_i;
                        if (bus.mem_we_i) begin
                            bus.mem_dout_o <= bus.mem_wdata_i[7:0];
                            bus.mem_wr_o   <= 1'b1;
                            r_state        <= ST_MEM_WR;
                        end else begin
                            r_state <= ST_MEM_RD;
                        end
                    end else if (w_if_go) begin
                        r_addr      <= bus.if_addr_i;
                        r_n         <= 3'd4;
                        r_buf       <= 32'd0;
                        bus.mem_a_o <= bus.if_addr_i;
                        r_state     <= ST_IF_RD;
                    end
                end

                ST_IF_RD, ST_MEM_RD: begin
                    if ((r_state == ST_IF_RD) && bus.if_flush_i) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= 3'd0;
                        bus.mem_a_o <= 32'd0;
                    end else begin
                        if (r_cnt != 3'd0) begin
                            r_buf <= w_buf_next;
                        end
                        if (r_cnt == r_n) begin
                            // Last byte captured this edge.
                            r_state     <= ST_IDLE;
                            r_cnt       <= 3'd0;
                            bus.mem_a_o <= 32'd0;
                            if (r_state == ST_IF_RD) begin
                                bus.if_data_o <= w_buf_next;
                                bus.if_done_o <= 1'b1;
                            end else begin
                                bus.mem_data_o <= w_buf_next;
                                bus.mem_done_o <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                            if (w_more) begin
                                bus.mem_a_o <= w_next_addr;
                            end
                        end
                    end
                end

                ST_MEM_WR: begin
                    if (w_more) begin
                        bus.mem_a_o    <= w_next_addr;
                        bus.mem_dout_o <= w_next_wbyte;
                        r_cnt          <= r_cnt + 3'd1;
                    end else begin
                        r_state        <= ST_IDLE;
                        r_cnt          <= 3'd0;
                        bus.mem_a_o    <= 32'd0;
                        bus.mem_dout_o <= 8'd0;
                        bus.mem_wr_o   <= 1'b0;
                        bus.mem_done_o <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Self-checking bench for mem_ctrl. A behavioural byte memory
//                model predicts load/fetch results and store byte streams;
//                a negedge monitor pops a scoreboard on every done pulse and
//                every RAM write.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if bus ();

    mem_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic st; logic [31:0] d; } mresp_t;

    logic [31:0] exp_if_q [$];
    mresp_t      exp_mem_q [$];
    wr_t         exp_wr_q [$];

    // ram: what the DUT actually wrote; model_mem: what the model predicts.
    logic [7:0] ram       [logic [31:0]];
    logic [7:0] model_mem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_byte(a);
    endfunction

    function automatic int nbytes(input logic [1:0] len);
        if (len == 2'b00) return 1;
        if (len == 2'b01) return 2;
        return 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM port: registered read, write on the same edge.
    always @(posedge clk) begin
        logic [7:0] v;
        v = ram_rd(bus.mem_a_o);
        if (bus.mem_wr_o === 1'b1) ram[bus.mem_a_o] = bus.mem_dout_o;
        bus.mem_din_i <= v;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.mem_wr_o === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_write", {24'd0, bus.mem_dout_o}, 32'hxxxxxxxx);
            end else begin
                wr_t w;
                w = exp_wr_q.pop_front();
                chk("wr_addr", bus.mem_a_o, w.a);
                chk("wr_data", {24'd0, bus.mem_dout_o}, {24'd0, w.d});
            end
        end
        if (bus.if_done_o === 1'b1) begin
            if (exp_if_q.size() == 0) chk("unexpected_if_done", bus.if_data_o, 32'hxxxxxxxx);
            else chk("if_data", bus.if_data_o, exp_if_q.pop_front());
        end
        if (bus.mem_done_o === 1'b1) begin
            if (exp_mem_q.size() == 0) begin
                chk("unexpected_mem_done", bus.mem_data_o, 32'hxxxxxxxx);
            end else begin
                mresp_t m;
                m = exp_mem_q.pop_front();
                if (!m.st) chk("mem_data", bus.mem_data_o, m.d);
            end
        end
    end

    // Model: push expectations for a fetch.
    task automatic push_if(input logic [31:0] addr);
        logic [31:0] e;
        for (int i = 0; i < 4; i++) e[8*i +: 8] = model_rd(addr + 32'(i));
        exp_if_q.push_back(e);
    endtask

    // Model: push expectations for a load/store; returns the byte count.
    task automatic push_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                            input logic [31:0] wdata, output int n);
        logic [31:0] e;
        n = nbytes(len);
        e = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (we) begin
                exp_wr_q.push_back('{a: addr + 32'(i), d: wdata[8*i +: 8]});
                model_mem[addr + 32'(i)] = wdata[8*i +: 8];
            end else begin
                e[8*i +: 8] = model_rd(addr + 32'(i));
            end
        end
        exp_mem_q.push_back('{st: we, d: e});
    endtask

    // Wait for a done pulse, checking the address sequence on the way.
    task automatic wait_done(input bit is_if, input logic [31:0] base, input int n_addr,
                             output int cyc);
        cyc = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k <= n_addr) chk("addr_seq", bus.mem_a_o, base + 32'(k) - 32'd1);
            if ((is_if ? bus.if_done_o : bus.mem_done_o) === 1'b1) begin
                cyc = k;
                break;
            end
        end
        if (cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got none expected %s done", is_if ? "if" : "mem");
        end
    endtask

    task automatic do_if(input logic [31:0] addr);
        int cyc;
        push_if(addr);
        @(negedge clk);
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = addr;
        wait_done(1'b1, addr, 4, cyc);
        if (cyc >= 0) chk("if_latency", 32'(cyc), 32'd6);
        bus.if_req_i = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int cyc, n;
        push_mem(we, len, addr, wdata, n);
        @(negedge clk);
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = we;
        bus.mem_len_i   = len;
        bus.mem_addr_i  = addr;
        bus.mem_wdata_i = wdata;
        wait_done(1'b0, addr, n, cyc);
        if (cyc >= 0) chk(we ? "st_latency" : "ld_latency", 32'(cyc), we ? 32'(n + 1) : 32'(n + 2));
        bus.mem_req_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a"},     bus.mem_a_o, 32'd0);
        chk({tag, "_dout"},  {24'd0, bus.mem_dout_o}, 32'd0);
        chk({tag, "_wr"},    {31'd0, bus.mem_wr_o}, 32'd0);
        chk({tag, "_ifd"},   {31'd0, bus.if_done_o}, 32'd0);
        chk({tag, "_memd"},  {31'd0, bus.mem_done_o}, 32'd0);
        chk({tag, "_ifdat"}, bus.if_data_o, 32'd0);
        chk({tag, "_mdat"},  bus.mem_data_o, 32'd0);
    endtask

    initial begin
        int cyc, n;
        logic [31:0] a;

        bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_flush_i = 0;
        bus.mem_req_i = 0; bus.mem_we_i = 0; bus.mem_len_i = 0;
        bus.mem_addr_i = 0; bus.mem_wdata_i = 0; bus.io_buffer_full_i = 0;

        ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h93;
        ram[32'h2001] = 8'h34; ram[32'h2002] = 8'h12;
        model_mem[32'h100] = 8'h13; model_mem[32'h101] = 8'h00;
        model_mem[32'h102] = 8'h00; model_mem[32'h103] = 8'h93;
        model_mem[32'h2001] = 8'h34; model_mem[32'h2002] = 8'h12;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("reset");

        // First fetch.
        do_if(32'h100);
        chk("first_fetch", bus.if_data_o, 32'h93000013);

        // Simultaneous fetch and load: MEM first, fetch after one idle cycle.
        push_mem(1'b0, 2'b01, 32'h2001, 32'd0, n);
        push_if(32'h100);
        @(negedge clk);
        bus.if_req_i = 1; bus.if_addr_i = 32'h100;
        bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_len_i = 2'b01; bus.mem_addr_i = 32'h2001;
        wait_done(1'b0, 32'h2001, 2, cyc);
        chk("prio_mem_latency", 32'(cyc), 32'd4);
        chk("prio_mem_data", bus.mem_data_o, 32'h00001234);
        bus.mem_req_i = 0;
        wait_done(1'b1, 32'h0, 0, cyc);
        chk("prio_if_latency", 32'(cyc), 32'd7);
        bus.if_req_i = 0;

        // Word store and read-back.
        do_mem(1'b1, 2'b11, 32'h1000, 32'hDEADBEEF);
        do_mem(1'b0, 2'b11, 32'h1000, 32'd0);
        chk("store_readback", bus.mem_data_o, 32'hDEADBEEF);

        // Store into the IO region while the UART buffer is full.
        push_mem(1'b1, 2'b00, 32'h30000, 32'h000000A5, n);
        @(negedge clk);
        bus.io_buffer_full_i = 1;
        bus.mem_req_i = 1; bus.mem_we_i = 1; bus.mem_len_i = 2'b00;
        bus.mem_addr_i = 32'h30000; bus.mem_wdata_i = 32'h000000A5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("io_hold_wr", {31'd0, bus.mem_wr_o}, 32'd0);
        end
        bus.io_buffer_full_i = 0;
        wait_done(1'b0, 32'h30000, 1, cyc);
        chk("io_release_latency", 32'(cyc), 32'd2);
        bus.mem_req_i = 0;

        // Flush during the second byte of a fetch.
        @(negedge clk);
        bus.if_req_i = 1; bus.if_addr_i = 32'h300;
        @(negedge clk);
        chk("flush_a0", bus.mem_a_o, 32'h300);
        @(negedge clk);
        chk("flush_a1", bus.mem_a_o, 32'h301);
        bus.if_flush_i = 1; bus.if_req_i = 0;
        @(negedge clk);
        chk("flush_a_zero", bus.mem_a_o, 32'd0);
        bus.if_flush_i = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("flush_no_done", {31'd0, bus.if_done_o}, 32'd0);
        end
        do_if(32'h200);

        // Address wrap-around.
        do_if(32'hFFFFFFFE);

        // Reset in the middle of a word store.
        exp_wr_q.push_back('{a: 32'h4000, d: 8'h0D});
        exp_wr_q.push_back('{a: 32'h4001, d: 8'hF0});
        model_mem[32'h4000] = 8'h0D;
        model_mem[32'h4001] = 8'hF0;
        @(negedge clk);
        bus.mem_req_i = 1; bus.mem_we_i = 1; bus.mem_len_i = 2'b11;
        bus.mem_addr_i = 32'h4000; bus.mem_wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        rst = 1; bus.mem_req_i = 0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        do_mem(1'b0, 2'b11, 32'h4000, 32'd0);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom() : (32'h5000 + 32'($urandom_range(0, 63)));
            case ($urandom_range(0, 2))
                0:       do_if(a);
                1:       do_mem(1'b0, 2'($urandom_range(0, 3)), a, 32'd0);
                default: do_mem(1'b1, 2'($urandom_range(0, 3)), a, $urandom());
            endcase
        end

        repeat (4) @(negedge clk);
        chk("if_queue_empty",  32'(exp_if_q.size()), 32'd0);
        chk("mem_queue_empty", 32'(exp_mem_q.size()), 32'd0);
        chk("wr_queue_empty",  32'(exp_wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that responds to the fetch stage's word-read requests and the MEM stage's load/store requests. It serialises each request into byte-wide accesses on the single 8-bit RAM/IO port, which has 1-cycle read latency. It returns assembled little-endian words with a one-cycle done pulse. It sits between the pipeline (IF, MEM) and the top-level RAM port in cpu.v.

## Interface
- No parameters. Widths come from defines.v: `InstAddrBus` is 32 bits, `DataBus` is 8 bits.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high (`RstEnable`)
- if_req_i  in  1  fetch request; held until if_done_o is seen
- if_addr_i  in  32  fetch byte address
- if_flush_i  in  1  branch taken; abort any IF transaction
- mem_req_i  in  1  load/store request; held until mem_done_o is seen
- mem_we_i  in  1  1 = store, 0 = load
- mem_len_i  in  2  00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes (10 is treated as 4 bytes)
- mem_addr_i  in  32  load/store base address
- mem_wdata_i  in  32  store data, little-endian
- io_buffer_full_i  in  1  UART buffer full
- mem_din_i  in  8  RAM read byte
- mem_a_o  out  32  RAM address
- mem_dout_o  out  8  RAM write byte
- mem_wr_o  out  1  1 = write
- if_done_o  out  1  one-cycle pulse: fetch complete
- if_data_o  out  32  fetched word
- mem_done_o  out  1  one-cycle pulse: load/store complete
- mem_data_o  out  32  load result, zero-extended (sign handling belongs to MEM)

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR. Byte counter `cnt` is 3 bits. Byte buffer is 32 bits.
- Acceptance happens only in IDLE, and not in a cycle where either done output is high.
  - MEM has priority over IF, since it is the older instruction.
  - A store is not accepted while io_buffer_full_i=1 and mem_addr_i[17:16]=2'b11; it waits in IDLE.
  - An IF request is not accepted while if_flush_i=1.
- Read of n bytes (IF: n=4; MEM: n from mem_len_i):
  - mem_a_o = addr+i is driven for i = 0..n-1 on consecutive cycles, with mem_wr_o=0.
  - Byte i arrives on mem_din_i the following cycle and is stored in buffer bits [8i+7:8i].
  - After the last byte is captured: done is pulsed, data is registered, state returns to IDLE, mem_a_o=0.
- Write of n bytes: each cycle drives mem_a_o=addr+i, mem_dout_o=wdata[8i+7:8i], mem_wr_o=1. After the last byte: mem_wr_o=0, mem_done_o pulses, state returns to IDLE.
- Address arithmetic is a full 32-bit add, so wrap-around at 0xFFFFFFFF→0 is legal.
- Unused upper bytes of mem_data_o are 0.
- Flush:
  - if_flush_i=1 in IF_RD aborts at that edge: state→IDLE, mem_a_o=0, no if_done_o.
  - A concurrently pending mem_req_i is accepted from IDLE on the next eligible edge.
  - Flush never affects MEM_RD or MEM_WR.
- Reset mid-transaction drops the transaction; no done is pulsed.

## Timing
- Reset values: state=IDLE, cnt=0, mem_a_o=0, mem_dout_o=0, mem_wr_o=0, if_done_o=0, mem_done_o=0, if_data_o=0, mem_data_o=0.
- Acceptance edge is E0. The first address is valid in the cycle after E0.
- Read of n bytes: done and data are visible in the cycle after edge E(n+1). A 4-byte fetch is 6 cycles from request sampling to done.
- Write of n bytes: mem_wr_o is high in the cycles after E0..E(n-1). mem_done_o is visible after edge En.
- Done lasts exactly one cycle. The requester deasserts req in that cycle. Earliest next acceptance is the edge ending the done cycle +1, i.e. back-to-back fetches have one idle cycle between transactions.
- mem_a_o, mem_dout_o and mem_wr_o are registered outputs; nothing combinational reaches the port.

## Structure
- Add to defines.v:
  - state encodings (`MemIdle`, `MemIfRd`, `MemRd`, `MemWr`)
  - length codes (`LenByte`=2'b00, `LenHalf`=2'b01, `LenWord`=2'b11)
  - IO region tag `IoTag`=2'b11
- Single flat module; no sub-module. The serialiser is small enough to share one counter across all three busy states.

## Test plan
- Reset, then if_req_i=1, if_addr_i=0x100, RAM[0x100..0x103]=13,00,00,93 → one if_done_o pulse in cycle 6 with if_data_o=0x93000013; mem_a_o sequence 0x100..0x103.
- if_req_i and mem_req_i (load, len=01, addr=0x2001) rise together → MEM is served first, mem_data_o=0x0000{RAM[0x2002],RAM[0x2001]}, then the fetch starts after one idle cycle.
- Store len=11, addr=0x1000, wdata=0xDEADBEEF → mem_wr_o high for 4 cycles writing EF,BE,AD,DE to 0x1000..0x1003; mem_done_o is visible in the cycle after the 4th edge following acceptance.
- Store len=00, addr=0x30000 with io_buffer_full_i=1 for 3 cycles → no mem_wr_o during those cycles; the write issues after it drops.
- if_flush_i pulsed during the 2nd byte of a fetch → mem_a_o=0 next cycle, no if_done_o; a new if_req_i at 0x200 then completes normally.
- Fetch at 0xFFFFFFFE → addresses FFFFFFFE, FFFFFFFF, 0, 1; rst asserted mid-store → all outputs return to reset values with no done pulse.
